mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (address, write data, write strobe, read data).
- Provides a 128 KB byte RAM with 1-cycle read latency, plus a memory-mapped I/O region at mem_a[17:16]==2'b11.
- The I/O region covers UART TX through a buffered FIFO with almost-full backpressure, UART RX byte read, a coherent 32-bit cycle counter, and the program-stop handshake.
- Sits between the CPU top and the UART transmitter/receiver.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (2^17 bytes)
TX_FIFO_LOG, 4, log2 of TX FIFO depth (16 entries)
FULL_MARGIN, 2, free-slot threshold at which io_buffer_full asserts

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; all state frozen when low
mem_a  input  32  CPU address bus
mem_wr  input  1  1 = write, 0 = read
cpu_dout  input  8  CPU write data
mem_din  output  8  read data to CPU, valid the cycle after the read
io_buffer_full  output  1  TX FIFO almost full
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX accepts a byte when tx_valid && tx_ready
rx_data  input  8  received UART byte
rx_valid  input  1  rx_data available
rx_pop  output  1  one-cycle pulse; consumes rx_data
program_stop  output  1  sticky; program has finished and TX has drained

Behaviour:
- Reset (rst_in low, async):
  - mem_din=0, tx_valid=0, rx_pop=0, io_buffer_full=0, program_stop=0.
  - FIFO pointers, cycle counter, snapshot and stop_pending cleared.
  - RAM contents are not reset.
- rdy_in low: no register, RAM, FIFO or counter update; outputs hold.
- Address decode: is_io = (mem_a[17:16]==2'b11); RAM index = mem_a[ADDR_WIDTH-1:0].
- RAM write (mem_wr=1, !is_io): ram[index] <= cpu_dout at the clock edge.
- RAM read (mem_wr=0, !is_io): ram[index] is registered; mem_din shows it the next cycle.
- mem_din mux: a registered source select (RAM / RX / counter byte) aligns the output with the 1-cycle latency.
- IO write to 0x30000:
  - Nonzero cpu_dout is pushed to the TX FIFO; 0x00 is ignored.
  - A push while the FIFO is full with no same-cycle pop is dropped.
- IO write to 0x30004:
  - Pushes 0x00 as the terminator (bypasses the zero filter) and sets stop_pending.
  - Further TX writes are still accepted.
- program_stop rises the cycle after stop_pending && FIFO empty && !tx_valid; it stays high until reset.
- IO read 0x30000: mem_din next cycle = rx_data if rx_valid, else 0x00. rx_pop pulses in the read cycle only when rx_valid.
- IO read 0x30004..0x30007:
  - Reading 0x30004 latches snapshot <= counter and returns snapshot byte 0, i.e. counter[7:0] at the read cycle.
  - 0x30005/6/7 return snapshot bytes 1/2/3, little-endian, without re-latching.
- Other IO addresses: writes ignored, reads return 0x00.
- Cycle counter: 32-bit, +1 on every rdy_in-high cycle, wraps at 0xFFFFFFFF -> 0.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop when full: both accepted, count unchanged.
- io_buffer_full = (free slots <= FULL_MARGIN), registered. The CPU sees it one cycle late; the margin absorbs in-flight writes.

Optional Feature:
- Macro IO_SIM_CONSOLE_EN.
- When defined: each accepted nonzero TX push also $write's the character; program_stop rising edge prints the counter value and calls $finish.
- When undefined: no simulation tasks; the block is synthesizable and behaviour is otherwise identical.

Decomposition:
- Package mem_io_pkg:
  - IO_UART_ADDR=32'h30000, IO_CLK_ADDR=32'h30004, IO_REGION_SEL=2'b11.
  - Read-source select enum {SRC_RAM, SRC_RX, SRC_CNT, SRC_ZERO}.
- One sub-module, io_tx_fifo: parameterised depth; push/pop/full/empty/free_count; simultaneous push and pop when full.

Test Plan:
- Write 0xA5 to 0x00123, then read 0x00123 -> mem_din=0xA5 exactly one cycle after the read; write 0x5A to 0x1FFFF, read back -> 0x5A.
- Write 'H', 0x00, 'i' to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only; FIFO empty afterwards.
- tx_ready=0, 14 writes to 0x30000 -> io_buffer_full=1 after the 14th; 16 accepted, 17th dropped; raise tx_ready -> 16 bytes drain in order.
- Hold rdy_in high 1000 cycles from reset, read 0x30004..0x30007 -> snapshot counter bytes coherent across the four reads; rdy_in low for 10 cycles -> counter does not advance.
- rx_valid=1, rx_data=0x37, read 0x30000 -> mem_din=0x37, rx_pop single pulse; rx_valid=0 read -> 0x00, no rx_pop.
- Write 'x' then write 0x30004 with tx_ready=0 -> program_stop stays 0; release tx_ready -> 0x78, 0x00 transmitted, then program_stop=1; assert rst_in low mid-drain -> all outputs reset immediately.

Source files
------------

// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared IO addresses and read-source select for mem_io_responder
package mem_io_pkg;

  localparam logic [31:0] IO_UART_ADDR  = 32'h0003_0000;
  localparam logic [31:0] IO_CLK_ADDR   = 32'h0003_0004;
  localparam logic [1:0]  IO_REGION_SEL = 2'b11;

  // Which registered byte drives mem_din in the cycle after a read
  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT,
    SRC_ZERO
  } rd_src_e;

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - circular TX byte FIFO; push and pop may coincide even when full
module io_tx_fifo #(
  parameter int LOG = 4,
  parameter int W   = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic [LOG:0] free_count
);

  localparam logic [LOG:0] DEPTH = (LOG+1)'(1 << LOG);

  logic [W-1:0]   slot_mem [0:(1<<LOG)-1];
  logic [LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG:0]   count_q, count_d;
  logic           full;
  logic           pop_ok;
  logic           push_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH);
  assign free_count = DEPTH - count_q;
  assign head_data  = slot_mem[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is allowed alongside it
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointer and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk_in) begin
    if (push_ok) slot_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus responder: RAM, UART TX/RX, cycle counter, stop; console under IO_SIM_CONSOLE_EN
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TX_FIFO_LOG = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);
  import mem_io_pkg::*;

  localparam logic [TX_FIFO_LOG:0] MARGIN = (TX_FIFO_LOG+1)'(FULL_MARGIN);

  logic [7:0] ram_mem [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] ram_rdata;

  rd_src_e    src_q, src_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [1:0] cnt_sel_q, cnt_sel_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] cnt_q, cnt_d;
  logic       stop_pending_q, stop_pending_d;
  logic       program_stop_q, program_stop_d;
  logic       buf_full_q, buf_full_d;

  logic       is_io, is_uart, is_clk_lat, is_clk_rng;
  logic       fifo_push, fifo_pop, fifo_empty;
  logic [7:0] fifo_data;
  logic [TX_FIFO_LOG:0] free_count;

  assign is_io      = (mem_a[17:16] == IO_REGION_SEL);
  assign is_uart    = (mem_a == IO_UART_ADDR);
  assign is_clk_lat = (mem_a == IO_CLK_ADDR);
  assign is_clk_rng = (mem_a[31:2] == IO_CLK_ADDR[31:2]);

  assign tx_valid       = !fifo_empty;
  assign io_buffer_full = buf_full_q;
  assign program_stop   = program_stop_q;
  assign rx_pop         = rst_in && rdy_in && !mem_wr && is_uart && rx_valid;

  io_tx_fifo #(
    .LOG (TX_FIFO_LOG),
    .W   (8)
  ) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (fifo_push),
    .push_data  (fifo_data),
    .pop        (fifo_pop),
    .head_data  (tx_data),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  // Decode the bus cycle into FIFO pushes, snapshot/RX capture and next-state of all registers
  always_comb begin
    src_d          = src_q;
    rx_byte_d      = rx_byte_q;
    cnt_sel_d      = cnt_sel_q;
    snap_d         = snap_q;
    cnt_d          = cnt_q;
    stop_pending_d = stop_pending_q;
    program_stop_d = program_stop_q;
    buf_full_d     = buf_full_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_data      = cpu_dout;
    if (rdy_in) begin
      cnt_d      = cnt_q + 32'd1;
      buf_full_d = (free_count <= MARGIN);
      fifo_pop   = tx_valid && tx_ready;
      if (stop_pending_q && fifo_empty && !tx_valid) program_stop_d = 1'b1;
      if (mem_wr) begin
        src_d = SRC_ZERO;
        if (is_uart) begin
          fifo_push = (cpu_dout != 8'h00);
        end else if (is_clk_lat) begin
          // Terminator byte goes through even though it is zero
          fifo_push      = 1'b1;
          fifo_data      = 8'h00;
          stop_pending_d = 1'b1;
        end
      end else begin
        if (!is_io) begin
          src_d = SRC_RAM;
        end else if (is_uart) begin
          src_d = rx_valid ? SRC_RX : SRC_ZERO;
          if (rx_valid) rx_byte_d = rx_data;
        end else if (is_clk_rng) begin
          src_d     = SRC_CNT;
          cnt_sel_d = mem_a[1:0];
          // Only byte 0 re-latches so the four byte reads see one coherent value
          if (is_clk_lat) snap_d = cnt_q;
        end else begin
          src_d = SRC_ZERO;
        end
      end
    end
  end

  // Control and IO state registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      src_q          <= SRC_ZERO;
      rx_byte_q      <= 8'h00;
      cnt_sel_q      <= 2'b00;
      snap_q         <= 32'h0;
      cnt_q          <= 32'h0;
      stop_pending_q <= 1'b0;
      program_stop_q <= 1'b0;
      buf_full_q     <= 1'b0;
    end else begin
      src_q          <= src_d;
      rx_byte_q      <= rx_byte_d;
      cnt_sel_q      <= cnt_sel_d;
      snap_q         <= snap_d;
      cnt_q          <= cnt_d;
      stop_pending_q <= stop_pending_d;
      program_stop_q <= program_stop_d;
      buf_full_q     <= buf_full_d;
    end
  end

  // Byte RAM: synchronous write and registered read, contents survive reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !is_io) begin
      if (mem_wr) ram_mem[mem_a[ADDR_WIDTH-1:0]] <= cpu_dout;
      else        ram_rdata <= ram_mem[mem_a[ADDR_WIDTH-1:0]];
    end
  end

  // Read-data mux driven by the registered source so data lines up with the 1-cycle latency
  always_comb begin
    mem_din = 8'h00;
    case (src_q)
      SRC_RAM: mem_din = ram_rdata;
      SRC_RX:  mem_din = rx_byte_q;
      SRC_CNT: begin
        case (cnt_sel_q)
          2'd0:    mem_din = snap_q[7:0];
          2'd1:    mem_din = snap_q[15:8];
          2'd2:    mem_din = snap_q[23:16];
          default: mem_din = snap_q[31:24];
        endcase
      end
      default: mem_din = 8'h00;
    endcase
  end

`ifdef IO_SIM_CONSOLE_EN
  logic push_acc;
  assign push_acc = fifo_push && ((free_count != '0) || fifo_pop);

  // Echo accepted characters and end the simulation when the program stops
  always @(posedge clk_in) begin
    if (rst_in && push_acc && (fifo_data != 8'h00)) $write("%c", fifo_data);
    if (rst_in && !program_stop_q && program_stop_d) begin
      $display("program_stop at cycle %0d", cnt_q);
      $finish;
    end
  end
`else
  // Synthesis build: no console side effects
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .cpu_dout       (cpu_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  // Record every byte handed to the UART; inputs are stable at the falling edge
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_wr   = 1'b1;
    mem_a    = a;
    cpu_dout = d;
    tick();
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_wr = 1'b0;
    mem_a  = a;
    tick();
  endtask

  initial begin
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    cpu_dout = 8'h00;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick();
    tick();
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_buf_full", io_buffer_full, 1'b0);
    chk("rst_program_stop", program_stop, 1'b0);

    // Counter: 1000 running cycles, then coherent snapshot bytes
    rst_in = 1'b1;
    repeat (1000) tick();
    rd(32'h30004); chk("cnt_b0", mem_din, 8'hE8);
    rd(32'h30006); chk("cnt_b2", mem_din, 8'h00);
    rd(32'h30007); chk("cnt_b3", mem_din, 8'h00);
    rd(32'h30005); chk("cnt_b1", mem_din, 8'h03);
    rdy_in = 1'b0;
    mem_a  = 32'h30004;
    repeat (10) tick();
    chk("frozen_mem_din", mem_din, 8'h03);
    rdy_in = 1'b1;
    rd(32'h30004); chk("cnt_after_freeze_b0", mem_din, 8'hEC);
    rd(32'h30005); chk("cnt_after_freeze_b1", mem_din, 8'h03);

    // RAM
    wr(32'h00123, 8'hA5);
    rd(32'h00123); chk("ram_123", mem_din, 8'hA5);
    wr(32'h1FFFF, 8'h5A);
    rd(32'h1FFFF); chk("ram_1ffff", mem_din, 8'h5A);
    rd(32'h00123); chk("ram_123_again", mem_din, 8'hA5);

    // RX
    rx_valid = 1'b1;
    rx_data  = 8'h37;
    mem_a    = 32'h30000;
    #1 chk("rx_pop_on", rx_pop, 1'b1);
    tick(); chk("rx_data", mem_din, 8'h37);
    mem_a = 32'h0;
    #1 chk("rx_pop_single", rx_pop, 1'b0);
    rx_valid = 1'b0;
    mem_a    = 32'h30000;
    #1 chk("rx_pop_idle", rx_pop, 1'b0);
    tick(); chk("rx_empty_data", mem_din, 8'h00);
    mem_a = 32'h0;

    // TX zero filter
    txq.delete();
    tx_ready = 1'b1;
    wr(32'h30000, 8'h48);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h69);
    repeat (4) tick();
    chk("hi_count", txq.size(), 2);
    chk("hi_0", txq[0], 8'h48);
    chk("hi_1", txq[1], 8'h69);
    chk("hi_empty", tx_valid, 1'b0);

    // Fill to almost-full, overflow, then simultaneous push/pop while full
    txq.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 13; i++) wr(32'h30000, 8'h41 + 8'(i));
    tick(); chk("full_after_13", io_buffer_full, 1'b0);
    wr(32'h30000, 8'h4E);
    tick(); chk("full_after_14", io_buffer_full, 1'b1);
    wr(32'h30000, 8'h4F);
    wr(32'h30000, 8'h50);
    wr(32'h30000, 8'h51);
    chk("fill_head", tx_data, 8'h41);
    chk("fill_valid", tx_valid, 1'b1);
    tx_ready = 1'b1;
    wr(32'h30000, 8'h52);
    repeat (20) tick();
    chk("drain_count", txq.size(), 17);
    for (int i = 0; i < 16; i++) chk($sformatf("drain_%0d", i), txq[i], 8'h41 + 8'(i));
    chk("drain_pushpop_full", txq[16], 8'h52);
    chk("drain_empty", tx_valid, 1'b0);
    chk("drain_not_full", io_buffer_full, 1'b0);

    // Program stop handshake
    txq.delete();
    tx_ready = 1'b0;
    wr(32'h30000, 8'h78);
    wr(32'h30004, 8'h00);
    repeat (3) tick();
    chk("stop_held", program_stop, 1'b0);
    chk("stop_pending_valid", tx_valid, 1'b1);
    tx_ready = 1'b1;
    repeat (6) tick();
    chk("stop_count", txq.size(), 2);
    chk("stop_0", txq[0], 8'h78);
    chk("stop_1", txq[1], 8'h00);
    chk("stop_set", program_stop, 1'b1);

    // Reset in the middle of a drain
    tx_ready = 1'b0;
    wr(32'h30000, 8'h31);
    wr(32'h30000, 8'h32);
    wr(32'h30000, 8'h33);
    rd(32'h00123); chk("pre_rst_ram", mem_din, 8'hA5);
    tx_ready = 1'b1;
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    mem_a    = 32'h30000;
    rst_in   = 1'b0;
    #1;
    chk("mid_rst_mem_din", mem_din, 8'h00);
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    chk("mid_rst_rx_pop", rx_pop, 1'b0);
    chk("mid_rst_buf_full", io_buffer_full, 1'b0);
    chk("mid_rst_program_stop", program_stop, 1'b0);
    rx_valid = 1'b0;
    mem_a    = 32'h0;
    tick();
    rst_in = 1'b1;
    repeat (3) tick();
    chk("post_rst_tx_valid", tx_valid, 1'b0);
    chk("post_rst_program_stop", program_stop, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
